// File: rtl/cnt_chk_pkg.sv
// Shared types for the counter-sequence checker: FSM state encoding and counter width.
package cnt_chk_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all-ones and stick there.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cnt_checker.sv
// Checks that a counter advances by one per valid sample and matches its sub-counter;
// locks after a run of good samples and counts errors seen while locked.
module cnt_checker
  import cnt_chk_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic [CNT_W-1:0] sub_cnt_value,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] exp_value
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  chk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [GOOD_W-1:0] good_run_q, good_run_d;
  logic [BAD_W-1:0]  bad_run_q, bad_run_d;
  logic              locked_q, err_pulse_q;
  logic [CNT_W-1:0]  exp_value_q;

  logic [CNT_W-1:0]  prev_inc_s;
  logic [GOOD_W-1:0] good_inc_s;
  logic [BAD_W-1:0]  bad_inc_s;
  logic              sample_good_s;
  logic              err_inc_s;

  assign prev_inc_s    = prev_q + 8'd1;
  assign good_inc_s    = good_run_q + GOOD_W'(1);
  assign bad_inc_s     = bad_run_q + BAD_W'(1);
  assign sample_good_s = (cnt_value == prev_inc_s) && (sub_cnt_value == cnt_value);

  // Next-state: only samples with a valid predecessor are judged good or bad.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    err_inc_s  = 1'b0;
    if (!en) begin
      prev_vld_d = 1'b0;
    end else begin
      prev_d     = cnt_value;
      prev_vld_d = 1'b1;
      if (prev_vld_q) begin
        case (state_q)
          HUNT: begin
            if (!sample_good_s) begin
              good_run_d = '0;
            end else if (good_inc_s == GOOD_W'(LOCK_CNT)) begin
              state_d    = LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = good_inc_s;
            end
          end
          LOCKED: begin
            err_inc_s = ~sample_good_s;
            if (sample_good_s) begin
              bad_run_d = '0;
            end else if (bad_inc_s == BAD_W'(LOSS_CNT)) begin
              state_d    = HUNT;
              bad_run_d  = '0;
              good_run_d = '0;
            end else begin
              bad_run_d = bad_inc_s;
            end
          end
          default: begin
            state_d    = HUNT;
            good_run_d = '0;
            bad_run_d  = '0;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      exp_value_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_inc_s;
      exp_value_q <= prev_vld_d ? (prev_d + 8'd1) : 8'd0;
    end
  end

  sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (err_clr),
    .inc_i  (err_inc_s),
    .count_o(err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign exp_value = exp_value_q;

endmodule

// File: doc/cnt_checker.md
CNT_CHECKER -- requirements
Module: cnt_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4: consecutive good samples needed to enter LOCKED.
REQ-002 The block SHALL have parameter LOSS_CNT, default 2: consecutive bad samples in LOCKED that force a return to HUNT.
REQ-003 The block SHALL have parameter ERR_W, default 16: width of err_count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  sample-valid; inputs are sampled only when en=1.
REQ-007 cnt_value  input  8  primary counter value under check.
REQ-008 sub_cnt_value  input  8  sub-counter value; must equal cnt_value.
REQ-009 err_clr  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  high while state is LOCKED.
REQ-011 err_pulse  output  1  one-cycle flag per bad sample seen in LOCKED.
REQ-012 err_count  output  ERR_W  saturating count of bad samples seen in LOCKED.
REQ-013 exp_value  output  8  next expected cnt_value, which is the last sample + 1 mod 256.

Function
REQ-014 A sample SHALL be a cycle with en=1.
- The block holds prev (8 bit) and prev_vld.
- Each sample loads prev with cnt_value and sets prev_vld=1.
REQ-015 A sample with prev_vld=1 SHALL be compared.
- Good: cnt_value == prev+1 (8-bit wrap, FF->00) and sub_cnt_value == cnt_value.
- Otherwise the sample is bad.
REQ-016 A sample with prev_vld=0 SHALL be neither good nor bad; it only loads prev.
REQ-017 A cycle with en=0 SHALL clear prev_vld and hold the FSM state, run counters, err_count and the outputs.
REQ-018 FSM states SHALL be HUNT and LOCKED; the reset state is HUNT.
REQ-019 In HUNT, good_run behaviour SHALL be:
- A good sample increments good_run.
- A bad sample clears good_run.
- When a good sample brings good_run to LOCK_CNT, the next state is LOCKED and good_run clears.
REQ-020 In LOCKED, bad-sample behaviour SHALL be:
- A bad sample asserts err_pulse on the next cycle, increments err_count and increments bad_run.
- A good sample clears bad_run.
REQ-021 In LOCKED, a bad sample that brings bad_run to LOSS_CNT SHALL move the FSM to HUNT and clear bad_run and good_run; that sample still counts as an error.
REQ-022 Bad samples in HUNT SHALL NOT assert err_pulse or change err_count.
REQ-023 All outputs SHALL be registered, with one-cycle latency from the sampling edge.
- locked rises on the cycle after the LOCK_CNT-th good sample.
REQ-024 err_count SHALL saturate at all-ones and not wrap.
REQ-025 If err_clr and an error increment occur in the same cycle, err_clr SHALL win and err_count becomes 0.
REQ-026 exp_value SHALL be prev+1 when prev_vld=1 and 0 when prev_vld=0.

Reset
REQ-027 Asserting rst_n low SHALL immediately force:
- HUNT
- prev=0 and prev_vld=0
- good_run=0 and bad_run=0
- locked=0, err_pulse=0, err_count=0, exp_value=0.
REQ-028 Reset mid-lock SHALL discard all history; relock requires one load sample plus LOCK_CNT good samples.

Structure
REQ-029 The shared package cnt_chk_pkg SHALL hold the FSM state enum (HUNT, LOCKED) and the 8-bit counter width constant.
REQ-030 A sub-module sat_cnt SHALL provide a saturating, clearable, width-parameterised counter, used for err_count.
- The run counters stay inline in cnt_checker.
REQ-031 Target implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-032 Lock acquisition, LOCK_CNT=4: after reset, en=1 with cnt_value=sub_cnt_value=0,1,2,3,4 -> locked rises the cycle after sample 4; err_count=0.
REQ-033 Wrap: while LOCKED, samples FE,FF,00,01 -> locked stays 1; err_pulse stays 0.
REQ-034 Single error: while LOCKED, samples 10,11,13,14 -> exactly one err_pulse, after 13; err_count=1; locked stays 1.
REQ-035 Loss and mismatch:
- While LOCKED, two bad samples in a row (cnt_value 20,40) -> err_count +2; locked falls after the second bad sample.
- Separately, sub_cnt_value=cnt_value+1 with cnt_value correct -> counted as a bad sample.
REQ-036 Gap, clear and saturation:
- en=0 for 3 cycles, then resume at any value -> no error; the first sample only reloads prev.
- err_clr coincident with an error -> err_count=0.
- With ERR_W=2, 5 errors -> err_count=3.
REQ-037 Reset mid-lock: rst_n low for 1 cycle while LOCKED -> locked and err_count are 0 immediately, without waiting for a clock edge.
